// File: rtl/mips_bus_arbiter.sv
// Avalon-MM master shared by NUM_CH requesters: arbitrates, registers the winner, drives one
// transaction honouring waitrequest, and returns (optionally byte-swapped) read data to the winner.
module mips_bus_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SWAP_EN  = 1,
    parameter int ARB_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_byteen,
    output logic [NUM_CH-1:0]          req_ready,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       busy,
    output logic [ADDR_W-1:0]          address,
    output logic                       read,
    output logic                       write,
    output logic [DATA_W-1:0]          writedata,
    output logic [DATA_W/8-1:0]        byteenable,
    input  logic                       waitrequest,
    input  logic [DATA_W-1:0]          readdata
);

    localparam int NB  = DATA_W / 8;
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LSB = $clog2(NB);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]        state;
    logic [CW-1:0]     ptr;
    logic [CW-1:0]     g_lat;
    logic [CW-1:0]     gnt;
    logic              any_vld;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [NB-1:0]     sel_be;
    logic              sel_write;

    // Bus is little-endian, core is big-endian: reverse byte lanes when enabled.
    function automatic logic [DATA_W-1:0] swap_data(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = d;
        if (SWAP_EN != 0) begin
            for (int b = 0; b < NB; b++) begin
                r[b*8 +: 8] = d[(NB-1-b)*8 +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [NB-1:0] swap_be(input logic [NB-1:0] d);
        logic [NB-1:0] r;
        r = d;
        if (SWAP_EN != 0) begin
            for (int b = 0; b < NB; b++) begin
                r[b] = d[NB-1-b];
            end
        end
        return r;
    endfunction

    // Grant search; descending loops so the preferred candidate is written last.
    always_comb begin
        int idx;
        idx     = 0;
        any_vld = 1'b0;
        gnt     = '0;
        if (ARB_MODE == 0 || NUM_CH == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req_valid[i]) begin
                    any_vld = 1'b1;
                    gnt     = CW'(i);
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                idx = (int'(ptr) + k) % NUM_CH;
                if (req_valid[idx]) begin
                    any_vld = 1'b1;
                    gnt     = CW'(idx);
                end
            end
        end
    end

    always_comb begin
        sel_addr            = req_addr[int'(gnt)*ADDR_W +: ADDR_W];
        sel_addr[LSB-1:0]   = '0;
        sel_wdata           = req_wdata[int'(gnt)*DATA_W +: DATA_W];
        sel_be              = req_byteen[int'(gnt)*NB +: NB];
        sel_write           = req_write[gnt];
    end

    always_comb begin
        req_ready = '0;
        if (!reset && state == IDLE && any_vld) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign busy = (state == ISSUE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= CW'(NUM_CH - 1);
            g_lat      <= '0;
            address    <= '0;
            writedata  <= '0;
            byteenable <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        state      <= ISSUE;
                        ptr        <= gnt;
                        g_lat      <= gnt;
                        address    <= sel_addr;
                        writedata  <= swap_data(sel_wdata);
                        byteenable <= swap_be(sel_be);
                        read       <= ~sel_write;
                        write      <= sel_write;
                    end
                end
                ISSUE: begin
                    if (!waitrequest) begin
                        state            <= IDLE;
                        read             <= 1'b0;
                        write            <= 1'b0;
                        rsp_valid[g_lat] <= 1'b1;
                        if (read) begin
                            rsp_rdata <= swap_data(readdata);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with shared stimulus and compares both
// against a transaction-level reference model every cycle.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_byteen;
    logic        waitrequest;
    logic [31:0] readdata;

    logic [1:0]  o_ready [2];
    logic [1:0]  o_rsp   [2];
    logic [31:0] o_rdata [2];
    logic        o_busy  [2];
    logic [31:0] o_addr  [2];
    logic        o_read  [2];
    logic        o_write [2];
    logic [31:0] o_wd    [2];
    logic [3:0]  o_be    [2];

    always #5 clk = ~clk;

    mips_bus_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .SWAP_EN(1), .ARB_MODE(0)) u_fx (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen),
        .req_ready(o_ready[0]), .rsp_valid(o_rsp[0]), .rsp_rdata(o_rdata[0]), .busy(o_busy[0]),
        .address(o_addr[0]), .read(o_read[0]), .write(o_write[0]), .writedata(o_wd[0]),
        .byteenable(o_be[0]), .waitrequest(waitrequest), .readdata(readdata));

    mips_bus_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .SWAP_EN(1), .ARB_MODE(1)) u_rr (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteen(req_byteen),
        .req_ready(o_ready[1]), .rsp_valid(o_rsp[1]), .rsp_rdata(o_rdata[1]), .busy(o_busy[1]),
        .address(o_addr[1]), .read(o_read[1]), .write(o_write[1]), .writedata(o_wd[1]),
        .byteenable(o_be[1]), .waitrequest(waitrequest), .readdata(readdata));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: index 0 = fixed priority, 1 = round robin.
    bit          m_busy  [2];
    int          m_ch    [2];
    bit          m_wr    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wd    [2];
    logic [3:0]  m_be    [2];
    int          m_last  [2];
    int          m_rsp   [2];
    logic [31:0] m_rdata [2];

    function automatic logic [31:0] bswap(input logic [31:0] x);
        logic [31:0] y;
        y = {<<8{x}};
        return y;
    endfunction

    function automatic logic [3:0] brev(input logic [3:0] x);
        logic [3:0] y;
        y = {<<{x}};
        return y;
    endfunction

    function automatic int pick(input int m, input logic [1:0] v);
        if (m == 0) begin
            for (int c = 0; c < 2; c++) if (v[c]) return c;
        end else begin
            for (int k = 1; k <= 2; k++) if (v[(m_last[m] + k) % 2]) return (m_last[m] + k) % 2;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_busy[m] = 0; m_ch[m] = 0; m_wr[m] = 0; m_last[m] = 1; m_rsp[m] = -1;
            m_rdata[m] = '0; m_addr[m] = '0; m_wd[m] = '0; m_be[m] = '0;
        end
    endtask

    task automatic compare();
        for (int m = 0; m < 2; m++) begin
            int g;
            logic [1:0] er, ev;
            g  = (!reset && !m_busy[m]) ? pick(m, req_valid) : -1;
            er = '0; ev = '0;
            if (g >= 0) er[g] = 1'b1;
            if (m_rsp[m] >= 0) ev[m_rsp[m]] = 1'b1;
            check($sformatf("ready[%0d]", m), 64'(o_ready[m]), 64'(er));
            check($sformatf("rsp_valid[%0d]", m), 64'(o_rsp[m]), 64'(ev));
            check($sformatf("rsp_rdata[%0d]", m), 64'(o_rdata[m]), 64'(m_rdata[m]));
            check($sformatf("busy[%0d]", m), 64'(o_busy[m]), 64'(m_busy[m]));
            check($sformatf("read[%0d]", m), 64'(o_read[m]), 64'(m_busy[m] && !m_wr[m]));
            check($sformatf("write[%0d]", m), 64'(o_write[m]), 64'(m_busy[m] && m_wr[m]));
            check($sformatf("rw_excl[%0d]", m), 64'(o_read[m] & o_write[m]), 64'd0);
            if (m_busy[m]) begin
                check($sformatf("address[%0d]", m), 64'(o_addr[m]), 64'(m_addr[m]));
                check($sformatf("writedata[%0d]", m), 64'(o_wd[m]), 64'(m_wd[m]));
                check($sformatf("byteenable[%0d]", m), 64'(o_be[m]), 64'(m_be[m]));
            end
        end
    endtask

    task automatic update();
        if (reset) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++) begin
            m_rsp[m] = -1;
            if (m_busy[m]) begin
                if (!waitrequest) begin
                    m_rsp[m]  = m_ch[m];
                    if (!m_wr[m]) m_rdata[m] = bswap(readdata);
                    m_busy[m] = 0;
                end
            end else begin
                int g;
                g = pick(m, req_valid);
                if (g >= 0) begin
                    m_ch[m]   = g;
                    m_wr[m]   = req_write[g];
                    m_addr[m] = req_addr[g*32 +: 32] & 32'hFFFF_FFFC;
                    m_wd[m]   = bswap(req_wdata[g*32 +: 32]);
                    m_be[m]   = brev(req_byteen[g*4 +: 4]);
                    m_last[m] = g;
                    m_busy[m] = 1;
                end
            end
        end
    endtask

    // One clock: check at negedge, advance model at posedge, return 1 time unit after the edge.
    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic set_req(input int c, input bit v, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        req_valid[c]          = v;
        req_write[c]          = w;
        req_addr[c*32 +: 32]  = a;
        req_wdata[c*32 +: 32] = d;
        req_byteen[c*4 +: 4]  = be;
    endtask

    logic [7:0] gr [2];
    logic [5:0] strobes;

    initial begin
        reset = 1'b1; waitrequest = 1'b1; readdata = '0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_byteen = '0;
        set_req(0, 1, 0, 32'h0000_0100, 32'h0, 4'hF);
        set_req(1, 1, 0, 32'h0000_0200, 32'h0, 4'hF);
        model_reset();
        step();
        step();

        // Reset mid-read
        reset = 1'b0;
        step();
        check("t1_read_before_reset", 64'(o_read[1]), 64'd1);
        reset = 1'b1;
        #1;
        check("t1_read_async_drop_fx", 64'(o_read[0]), 64'd0);
        check("t1_read_async_drop_rr", 64'(o_read[1]), 64'd0);
        model_reset();
        step();
        reset = 1'b0;
        #1;
        check("t1_regrant_ch0", 64'(o_ready[1]), 64'b01);
        step();
        waitrequest = 1'b0; req_valid = '0;
        step();
        step();

        // Single read, zero wait, swapped data
        set_req(0, 1, 0, 32'hBFC0_0000, 32'h0, 4'hF);
        readdata = 32'h7856_3412;
        step();
        req_valid = '0;
        check("t2_read_strobe", 64'(o_read[1]), 64'd1);
        check("t2_address", 64'(o_addr[1]), 64'hBFC0_0000);
        step();
        check("t2_rsp_valid", 64'(o_rsp[1]), 64'b01);
        check("t2_rsp_rdata", 64'(o_rdata[1]), 64'h1234_5678);
        step();
        check("t2_rsp_single_pulse", 64'(o_rsp[1]), 64'b00);

        // Write with three wait cycles
        set_req(1, 1, 1, 32'h0000_1003, 32'hAABB_CCDD, 4'b0001);
        waitrequest = 1'b1;
        step();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) waitrequest = 1'b0;
            check("t3_address", 64'(o_addr[1]), 64'h1000);
            check("t3_writedata", 64'(o_wd[1]), 64'hDDCC_BBAA);
            check("t3_byteenable", 64'(o_be[1]), 64'b1000);
            check("t3_write", 64'(o_write[1]), 64'd1);
            step();
        end
        check("t3_rsp_valid", 64'(o_rsp[1]), 64'b10);

        // Continuous contention
        set_req(0, 1, 0, 32'h0000_2000, 32'h0, 4'hF);
        set_req(1, 1, 0, 32'h0000_3000, 32'h0, 4'hF);
        gr[0] = '0; gr[1] = '0;
        for (int i = 0; i < 8; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (o_ready[m] != 2'b00) gr[m] = {gr[m][5:0], (o_ready[m] == 2'b10) ? 2'd1 : 2'd0};
            end
            step();
        end
        check("t4_grants_fixed", 64'(gr[0]), 64'h00);
        check("t4_grants_rr", 64'(gr[1]), 64'h11);

        // Back-to-back reads from ch0
        req_valid = 2'b01;
        strobes = '0;
        for (int i = 0; i < 6; i++) begin
            strobes = {strobes[4:0], o_read[1]};
            step();
        end
        check("t5_strobe_spacing", 64'(strobes), 64'b010101);
        req_valid = '0;
        step();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < 2; c++) begin
                set_req(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
                        4'($urandom_range(0, 15)));
            end
            waitrequest = ($urandom_range(0, 2) == 0);
            readdata    = $urandom();
            reset       = ($urandom_range(0, 59) == 0);
            if (reset) begin
                #1;
                model_reset();
            end
            step();
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
